// File: rtl/comp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and the {aeqb, agtb, altb} result encoding.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Result vector ordering is {aeqb, agtb, altb}; exactly one bit is set once a compare completes.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  function automatic logic [2:0] res_encode(input logic eq, input logic gt);
    if (eq) return RES_EQ;
    return gt ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational C-bit unsigned comparator applied to the top chunk of the
// operand shift registers.
module comp_chunk #(
  parameter int C = 2
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  output logic         eq,
  output logic         gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/comp_secuencial.sv
// Multi-cycle MSB-first magnitude comparator, C bits per clock with early exit.
// Optional macro COMP_SIGNED_EN adds a signed_mode input for two's-complement compares.
module comp_secuencial
  import comp_pkg::*;
#(
  parameter int W = 16,
  parameter int C = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef COMP_SIGNED_EN
  input  logic         signed_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb
);

  localparam int N     = W / C;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [C-1:0] MSB_M = C'(1) << (C - 1);

  state_e             state_q;
  logic [W-1:0]       a_q, b_q;
  logic [W-1:0]       a_d, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, done_q;
  logic [2:0]         res_q;
`ifdef COMP_SIGNED_EN
  logic               sgn_q;
`endif

  logic               flip;
  logic [C-1:0]       top_a, top_b;
  logic               chunk_eq, chunk_gt;

  // Offset-binary trick: flipping the sign bit of both operands turns a
  // signed compare into an unsigned one; only the first chunk holds it.
  always_comb begin
    flip = 1'b0;
`ifdef COMP_SIGNED_EN
    flip = sgn_q && (cnt_q == CNT_W'(N - 1));
`endif
    top_a = a_q[W-1 -: C] ^ (flip ? MSB_M : '0);
    top_b = b_q[W-1 -: C] ^ (flip ? MSB_M : '0);
  end

  assign a_d   = a_q << C;
  assign b_d   = b_q << C;
  assign cnt_d = cnt_q - CNT_W'(1);

  comp_chunk #(.C(C)) u_chunk (
    .a  (top_a),
    .b  (top_b),
    .eq (chunk_eq),
    .gt (chunk_gt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= RES_NONE;
`ifdef COMP_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= CNT_W'(N - 1);
            busy_q  <= 1'b1;
            res_q   <= RES_NONE;
            state_q <= COMPARE;
`ifdef COMP_SIGNED_EN
            sgn_q   <= signed_mode;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        COMPARE: begin
          if (!chunk_eq) begin
            res_q   <= res_encode(1'b0, chunk_gt);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q != '0) begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
          end else begin
            res_q   <= res_encode(1'b1, 1'b0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign aeqb = res_q[2];
  assign agtb = res_q[1];
  assign altb = res_q[0];

endmodule
